// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_pkg : shared types and constants for the I2C target blocks       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_IGNORE    = 4'd9
  } i2c_tgt_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_bus_sync : SCL/SDA synchronizer with edge and START/STOP detect  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_prev;
  logic       r_sda_prev;
  logic       w_scl;
  logic       w_sda;

  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
  // SDA aligned with the registered event strobes
  assign sda_s = r_sda_prev;

  // Idle-bus reset values keep the first cycles after reset free of phantom events
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_i};
      r_sda_sync <= {r_sda_sync[0], sda_i};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
      scl_rise   <=  w_scl & ~r_scl_prev;
      scl_fall   <= ~w_scl &  r_scl_prev;
      start_det  <=  w_scl &  r_scl_prev &  r_sda_prev & ~w_sda;
      stop_det   <=  w_scl &  r_scl_prev & ~r_sda_prev &  w_sda;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_target_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_target_regs : I2C target with auto-incrementing register file    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h34,
  parameter int         REG_DEPTH   = 16,
  localparam int        AW          = $clog2(REG_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start_det;
  logic w_stop_det;
  logic w_sda_s;

  i2c_bus_sync u_bus_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start_det),
    .stop_det  (w_stop_det),
    .sda_s     (w_sda_s)
  );

  i2c_tgt_state_t r_state, w_state_nxt;
  logic [3:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic [AW-1:0]  r_ptr, w_ptr_nxt;
  logic           r_sda_oe, w_sda_oe_nxt;
  logic           r_rw, w_rw_nxt;
  logic           r_first, w_first_nxt;
  logic           w_reg_we;
  logic [7:0]     w_byte;
  logic [7:0]     w_rd_byte;
  logic [AW-1:0]  w_ptr_inc;
  logic [7:0]     r_regs [REG_DEPTH];

  assign w_byte    = {r_shift[6:0], w_sda_s};
  assign w_rd_byte = r_regs[r_ptr];
  assign w_ptr_inc = r_ptr + AW'(1);
  assign sda_oe    = r_sda_oe;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_sda_oe  <= 1'b0;
      r_rw      <= 1'b0;
      r_first   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ptr     <= w_ptr_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      r_rw      <= w_rw_nxt;
      r_first   <= w_first_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_ptr_nxt     = r_ptr;
    w_sda_oe_nxt  = r_sda_oe;
    w_rw_nxt      = r_rw;
    w_first_nxt   = r_first;
    w_reg_we      = 1'b0;

    if (w_stop_det) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
    end else if (w_start_det) begin
      w_state_nxt   = S_ADDR;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
      w_first_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_bit_cnt_nxt = '0;
              if (r_state == S_ADDR) begin
                if (w_byte[7:1] == TARGET_ADDR) begin
                  w_rw_nxt    = w_byte[0];
                  w_state_nxt = S_ADDR_ACK;
                end else begin
                  w_state_nxt = S_IGNORE;
                end
              end else if (r_state == S_PTR) begin
                w_ptr_nxt   = w_byte[AW-1:0];
                w_state_nxt = S_PTR_ACK;
              end else begin
                w_reg_we    = 1'b1;
                w_ptr_nxt   = w_ptr_inc;
                w_state_nxt = S_WDATA_ACK;
              end
            end
          end
        end

        // First falling edge starts the ACK, the next one ends it
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = ~I2C_ACK;
            end else if (r_state == S_ADDR_ACK && r_rw) begin
              w_shift_nxt   = w_rd_byte;
              w_ptr_nxt     = w_ptr_inc;
              w_sda_oe_nxt  = ~w_rd_byte[7];
              w_bit_cnt_nxt = '0;
              w_state_nxt   = S_RDATA;
            end else begin
              w_sda_oe_nxt  = 1'b0;
              w_bit_cnt_nxt = '0;
              w_state_nxt   = (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
            end
          end
        end

        S_RDATA: begin
          if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_first) begin
              w_sda_oe_nxt = ~r_shift[7];
              w_first_nxt  = 1'b0;
            end else if (r_bit_cnt == 4'd8) begin
              w_sda_oe_nxt  = 1'b0;
              w_bit_cnt_nxt = '0;
              w_state_nxt   = S_RDATA_ACK;
            end else begin
              w_sda_oe_nxt = ~r_shift[6];
              w_shift_nxt  = {r_shift[6:0], 1'b0};
            end
          end
        end

        // Reload on the ACK rise; the first bit goes out on the following fall
        S_RDATA_ACK: begin
          if (w_scl_rise) begin
            if (w_sda_s == I2C_ACK) begin
              w_shift_nxt   = w_rd_byte;
              w_ptr_nxt     = w_ptr_inc;
              w_bit_cnt_nxt = '0;
              w_first_nxt   = 1'b1;
              w_state_nxt   = S_RDATA;
            end else begin
              w_state_nxt = S_IGNORE;
            end
          end
        end

        default: ;
      endcase
    end
  end

  // I2C write is applied last so it wins a same-index collision with the host
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      host_rdata <= '0;
      for (int i = 0; i < REG_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      wr_valid <= w_reg_we;
      if (w_reg_we) begin
        wr_addr <= r_ptr;
        wr_data <= w_byte;
      end
      if (host_we) begin
        r_regs[host_addr] <= host_wdata;
      end
      if (w_reg_we) begin
        r_regs[r_ptr] <= w_byte;
      end
      host_rdata <= r_regs[host_addr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_i2c_target_regs : bus-level bench with a register/pointer model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_i2c_target_regs;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          scl_m;
  logic          sda_m;
  logic          sda_bus;
  logic          sda_oe;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic [7:0]    host_rdata;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs #(
    .TARGET_ADDR (7'h34),
    .REG_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_m),
    .sda_i      (sda_bus),
    .sda_oe     (sda_oe),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  // Reference model: register contents, pointer, expected write events
  logic [7:0] mregs [DEPTH];
  int         mptr;
  int         exp_wr [$];
  int         got_wr [$];
  int         oe_cycles = 0;
  logic [7:0] wbuf [4];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && wr_valid) got_wr.push_back(int'(wr_addr) * 256 + int'(wr_data));
    if (sda_oe) oe_cycles++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks so far", n_pass, n_chk);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(5);
    scl_m = 1'b1; tick(10);
    sda_m = 1'b0; tick(10);
    scl_m = 1'b0; tick(5);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(5);
    scl_m = 1'b1; tick(10);
    sda_m = 1'b1; tick(10);
  endtask

  // Optional host write lands on the same clock as the I2C register write
  task automatic i2c_wr_byte(input logic [7:0] b, input bit coll, input int haddr,
                             input logic [7:0] hdata, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(5);
      scl_m = 1'b1;
      if (coll && i == 0) begin
        tick(3);
        host_addr  = haddr[AW-1:0];
        host_wdata = hdata;
        host_we    = 1'b1;
        tick(1);
        host_we    = 1'b0;
        tick(6);
      end else begin
        tick(10);
      end
      scl_m = 1'b0; tick(5);
    end
    sda_m = 1'b1; tick(5);
    scl_m = 1'b1; tick(5);
    ack = sda_bus; tick(5);
    scl_m = 1'b0; tick(5);
  endtask

  task automatic i2c_rd_byte(input logic ackbit, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; tick(5);
      scl_m = 1'b1; tick(5);
      b[i] = sda_bus; tick(5);
      scl_m = 1'b0; tick(5);
    end
    sda_m = ackbit; tick(5);
    scl_m = 1'b1; tick(10);
    scl_m = 1'b0; tick(5);
  endtask

  task automatic host_wr(input int a, input logic [7:0] d);
    host_addr  = a[AW-1:0];
    host_wdata = d;
    host_we    = 1'b1;
    tick(1);
    host_we    = 1'b0;
    mregs[a]   = d;
  endtask

  task automatic host_rd(input int a, output logic [7:0] v);
    host_addr = a[AW-1:0];
    tick(2);
    v = host_rdata;
  endtask

  task automatic compare_wr();
    check("wr_count", got_wr.size(), exp_wr.size());
    while (got_wr.size() > 0 && exp_wr.size() > 0)
      check("wr_event", got_wr.pop_front(), exp_wr.pop_front());
    got_wr.delete();
    exp_wr.delete();
  endtask

  task automatic do_write(input logic [7:0] ptr_b, input int n, input int coll_idx,
                          input int haddr, input logic [7:0] hdata);
    logic ack;
    int   p;
    i2c_start();
    check("busy_in_txn", busy, 1'b1);
    i2c_wr_byte(8'h68, 1'b0, 0, 8'h00, ack); check("wr_addr_ack", ack, 1'b0);
    i2c_wr_byte(ptr_b, 1'b0, 0, 8'h00, ack); check("wr_ptr_ack", ack, 1'b0);
    p = int'(ptr_b) % DEPTH;
    for (int i = 0; i < n; i++) begin
      i2c_wr_byte(wbuf[i], (i == coll_idx), haddr, hdata, ack);
      check("wr_data_ack", ack, 1'b0);
      exp_wr.push_back(p * 256 + int'(wbuf[i]));
      if (i == coll_idx && haddr != p) mregs[haddr] = hdata;
      mregs[p] = wbuf[i];
      p = (p + 1) % DEPTH;
    end
    mptr = p;
    i2c_stop();
    tick(5);
    check("busy_after_stop", busy, 1'b0);
    compare_wr();
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] ptr_b, input int n);
    logic       ack;
    logic [7:0] b;
    i2c_start();
    if (set_ptr) begin
      i2c_wr_byte(8'h68, 1'b0, 0, 8'h00, ack); check("rd_waddr_ack", ack, 1'b0);
      i2c_wr_byte(ptr_b, 1'b0, 0, 8'h00, ack); check("rd_ptr_ack", ack, 1'b0);
      mptr = int'(ptr_b) % DEPTH;
      i2c_start();
    end
    i2c_wr_byte(8'h69, 1'b0, 0, 8'h00, ack); check("rd_addr_ack", ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      i2c_rd_byte((i == n - 1), b);
      check("rd_data", b, mregs[mptr]);
      mptr = (mptr + 1) % DEPTH;
    end
    check("rd_release_after_nack", sda_oe, 1'b0);
    i2c_stop();
    tick(5);
    check("rd_busy_after_stop", busy, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] v;
    int         c0;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < DEPTH; i++) mregs[i] = 8'h00;
    mptr = 0;
    tick(5);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_addr", wr_addr, '0);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_host_rdata", host_rdata, 8'h00);
    rst = 1'b0;
    tick(5);

    // Basic write
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    do_write(8'h03, 2, -1, 0, 8'h00);
    host_rd(3, v); check("host_rd_3", v, 8'hA5);
    host_rd(4, v); check("host_rd_4", v, 8'h5A);

    // Pointer write, repeated START, 2-byte read
    host_wr(7, 8'h11);
    host_wr(8, 8'h22);
    do_read(1'b1, 8'h07, 2);

    // Address mismatch: no ACK, no writes, SDA never pulled
    c0 = oe_cycles;
    i2c_start();
    i2c_wr_byte(8'h6A, 1'b0, 0, 8'h00, ack); check("nomatch_addr_nack", ack, 1'b1);
    for (int i = 0; i < 3; i++) begin
      i2c_wr_byte(8'($urandom_range(0, 255)), 1'b0, 0, 8'h00, ack);
      check("nomatch_data_nack", ack, 1'b1);
    end
    check("nomatch_busy", busy, 1'b1);
    i2c_stop();
    tick(5);
    check("nomatch_busy_after_stop", busy, 1'b0);
    check("nomatch_oe_cycles", oe_cycles - c0, 0);
    compare_wr();

    // Pointer modulo depth and wrap
    wbuf[0] = 8'h01; wbuf[1] = 8'h02;
    do_write(8'h1F, 2, -1, 0, 8'h00);
    host_rd(15, v); check("wrap_rd_15", v, 8'h01);
    host_rd(0, v);  check("wrap_rd_0", v, 8'h02);

    // Same-index and different-index collisions
    wbuf[0] = 8'hC3;
    do_write(8'h05, 1, 0, 5, 8'h00);
    wbuf[0] = 8'h3C;
    do_write(8'h06, 1, 0, 9, 8'h77);
    host_rd(5, v); check("coll_same_idx", v, 8'hC3);
    host_rd(6, v); check("coll_i2c_idx", v, 8'h3C);
    host_rd(9, v); check("coll_host_idx", v, 8'h77);

    // Randomized traffic against the model
    for (int it = 0; it < 10; it++) begin
      int n;
      n = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
        do_write(8'($urandom_range(0, 255)), n, -1, 0, 8'h00);
      end else begin
        do_read(1'b1, 8'($urandom_range(0, 255)), n);
      end
    end

    // Reset during bit 4 of a read data byte
    host_wr(2, 8'h00);
    i2c_start();
    i2c_wr_byte(8'h68, 1'b0, 0, 8'h00, ack); check("rst_txn_addr_ack", ack, 1'b0);
    i2c_wr_byte(8'h02, 1'b0, 0, 8'h00, ack); check("rst_txn_ptr_ack", ack, 1'b0);
    i2c_start();
    i2c_wr_byte(8'h69, 1'b0, 0, 8'h00, ack); check("rst_txn_raddr_ack", ack, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sda_m = 1'b1; tick(5);
      scl_m = 1'b1; tick(10);
      scl_m = 1'b0; tick(5);
    end
    tick(5);
    check("oe_before_rst", sda_oe, 1'b1);
    rst = 1'b1;
    tick(1);
    check("oe_after_rst", sda_oe, 1'b0);
    check("busy_after_rst", busy, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) mregs[i] = 8'h00;
    mptr = 0;
    got_wr.delete();
    i2c_stop();
    tick(5);
    host_rd(3, v); check("regs_cleared_3", v, 8'h00);
    host_rd(7, v); check("regs_cleared_7", v, 8'h00);
    host_wr(0, 8'h5C);
    do_read(1'b0, 8'h00, 1);
    wbuf[0] = 8'h99; wbuf[1] = 8'h44;
    do_write(8'h0A, 2, -1, 0, 8'h00);
    host_rd(10, v); check("post_rst_wr_10", v, 8'h99);

    // Full register sweep against the model
    for (int i = 0; i < DEPTH; i++) begin
      host_rd(i, v);
      check("final_regs", v, mregs[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (responder) with a small byte-addressable register file. It is the far end of the I2C initiator inside `Top_Cmp`: it sits on `scl_pin`/`sda_pin` in benches and system builds and emulates the sensor that `Top_Cmp` commands. It ACKs its own 7-bit address and accepts a register-pointer byte, then write bytes. Reads auto-increment. A host-side port preloads and inspects the registers.

## Interface
- `TARGET_ADDR`, 7'h34, 7-bit I2C address the block responds to.
- `REG_DEPTH`, 16, number of 8-bit registers; power of two, 2..256.
- `AW`, $clog2(REG_DEPTH), local parameter, register index width.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `scl_i`  in  1  SCL pin level, asynchronous.
- `sda_i`  in  1  SDA pin level, asynchronous.
- `sda_oe`  out  1  1 = pull SDA low; the top level ties it into the `wand` SDA net as `~sda_oe`.
- `host_we`  in  1  host register write strobe.
- `host_addr`  in  AW  host register index for write/read.
- `host_wdata`  in  8  host write data.
- `host_rdata`  out  8  `regs[host_addr]`, registered, 1-cycle latency.
- `wr_valid`  out  1  1-cycle pulse on every register written over I2C.
- `wr_addr`  out  AW  index of that write.
- `wr_data`  out  8  data of that write.
- `busy`  out  1  high from START until STOP, or until the return to IDLE.

## Operation
- **Input conditioning:** `scl_i`/`sda_i` pass through a 2-FF synchronizer, then one history register. Edges are detected on the synchronized values.
- **Bus events:**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - A data bit is sampled on the SCL rising edge.
  - `sda_oe` changes only on the cycle after a detected SCL falling edge.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- **Transitions:**
  - From any state, START → ADDR, with the bit counter cleared and `sda_oe`=0.
  - From any state, STOP → IDLE.
  - ADDR: after 8 bits, if `addr[7:1]==TARGET_ADDR` → ADDR_ACK. Otherwise → IGNORE, with no ACK and `sda_oe` held 0 until START/STOP.
  - ADDR_ACK: drive ACK for the 9th clock. Then go to PTR if R/W=0. If R/W=1, load the shift register from `regs[ptr]`, increment `ptr`, and go to RDATA.
  - PTR: after 8 bits, `ptr <= byte[AW-1:0]`; the upper bits are ignored (modulo `REG_DEPTH`). Then ACK → WDATA.
  - WDATA: after 8 bits, write `regs[ptr]`, pulse `wr_valid`, increment `ptr`, ACK, and return to WDATA.
  - RDATA: shift MSB first; `sda_oe = ~bit`. After 8 bits, release SDA → RDATA_ACK.
  - RDATA_ACK: sample the master's bit. ACK(0) → reload from `regs[ptr]`, increment `ptr`, go to RDATA. NACK(1) → IGNORE.
- **Pointer:** `ptr` persists across transactions, including a repeated START. This enables write-pointer-then-read. `ptr` wraps from `REG_DEPTH-1` to 0.
- **Collision:** if an I2C write and `host_we` hit the same index in the same cycle, the I2C write wins. If they hit different indices, both take effect.
- **Clock stretching:** none. SCL is never driven.

## Timing
- **Reset values:** `sda_oe`=0, `busy`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `host_rdata`=0, `ptr`=0, all `regs`=0, state IDLE.
- **Reset mid-transfer:** SDA is released in the cycle after `rst` is sampled, and the in-flight byte is discarded.
- **Detection latency:** pin change to detected edge is 3 `clk`. SDA responds 4 `clk` after the SCL pin falls.
- **Requirement:** SCL high and low phases are each ≥ 8 `clk`.
- **`wr_valid`:** asserted in the cycle after the 8th data bit is sampled; `regs` reflects the new value in the same cycle.
- **ACK drive:** `sda_oe` is asserted after the 8th SCL falling edge and released after the 9th.
- **Host port:** a host write is visible on `host_rdata` 2 cycles after `host_we`, with `host_addr` held.

## Structure
- Package `i2c_pkg`: the state enum `i2c_tgt_state_t`, `I2C_ACK`=1'b0, `I2C_NACK`=1'b1.
- Sub-module `i2c_bus_sync`: 2-FF sync plus edge/START/STOP detect. Outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`. It is reusable by a future target or monitor.
- The register file is inferred as a flat array in the top module.

## Test plan
- **Write:** START, 0x68, 0x03, 0xA5, 0x5A, STOP → ACK on every byte; `wr_valid` pulses at (3,0xA5) then (4,0x5A); `host_rdata`@3 = 0xA5.
- **Read:** preload via host `regs[7]`=0x11 and `regs[8]`=0x22; START 0x68 0x07, repeated START 0x69, read 2 bytes ACK/NACK, STOP → bus returns 0x11, 0x22; SDA is released after the NACK.
- **Address mismatch:** START 0x6A, 3 bytes, STOP → `sda_oe` stays 0 throughout; no `wr_valid`; `busy` falls at STOP.
- **Wrap:** pointer 0x1F with `REG_DEPTH`=16 → first write lands at index 15, second at 0.
- **Collision:** `host_we` to index 5 with 0x00 in the same cycle as an I2C write of 0xC3 to index 5 → `regs[5]`=0xC3.
- **Reset:** assert `rst` during bit 4 of a read data byte → `sda_oe`=0 the next cycle, `ptr`=0, `regs` cleared; a subsequent full write transaction succeeds.
